// File: rtl/vote_result_scanner_pkg.sv
// Shared types and sizing for the vote result scanner.
// Holds the FSM state encoding and the tally/total widths.
package vote_result_scanner_pkg;

  localparam int NUM_CAND = 4;
  localparam int TALLY_W  = 8;
  localparam int TOTAL_W  = 10;
  localparam int IDX_W    = $clog2(NUM_CAND);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vote_result_scanner_max_tracker.sv
// Running max / winner / tie / total over one snapshot entry per step.
// The *_nxt_o outputs show the values after the current step, so the caller can latch the final result on the last step.
module vote_max_tracker
  import vote_result_scanner_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               step_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [TALLY_W-1:0] entry_i,
  output logic [TALLY_W-1:0] max_nxt_o,
  output logic [IDX_W-1:0]   winner_nxt_o,
  output logic               tie_nxt_o,
  output logic [TOTAL_W-1:0] total_nxt_o
);

  logic [TALLY_W-1:0] max_q,    max_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic               tie_q,    tie_d;
  logic [TOTAL_W-1:0] total_q,  total_d;

  always_comb begin
    max_d    = max_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    total_d  = total_q;
    if (step_i) begin
      total_d = total_q + {{(TOTAL_W-TALLY_W){1'b0}}, entry_i};
      if (idx_i == '0) begin
        max_d    = entry_i;
        winner_d = '0;
        tie_d    = 1'b0;
      end else if (entry_i > max_q) begin
        max_d    = entry_i;
        winner_d = idx_i;
        tie_d    = 1'b0;
      end else if (entry_i == max_q) begin
        // Equal tally keeps the earlier candidate: lowest index wins.
        tie_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_q    <= '0;
      winner_q <= '0;
      tie_q    <= 1'b0;
      total_q  <= '0;
    end else if (clr_i) begin
      max_q    <= '0;
      winner_q <= '0;
      tie_q    <= 1'b0;
      total_q  <= '0;
    end else if (step_i) begin
      max_q    <= max_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      total_q  <= total_d;
    end
  end

  assign max_nxt_o    = max_d;
  assign winner_nxt_o = winner_d;
  assign tie_nxt_o    = tie_d;
  assign total_nxt_o  = total_d;

endmodule

// File: rtl/vote_result_scanner.sv
// Snapshots four candidate tallies on an accepted start and scans them one per cycle;
// result_valid rises 4 edges after acceptance and holds until result_ready.
module vote_result_scanner
  import vote_result_scanner_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               mode_i,
  input  logic               start_i,
  input  logic [TALLY_W-1:0] cand1_vote_recvd_i,
  input  logic [TALLY_W-1:0] cand2_vote_recvd_i,
  input  logic [TALLY_W-1:0] cand3_vote_recvd_i,
  input  logic [TALLY_W-1:0] cand4_vote_recvd_i,
  input  logic               result_ready_i,
  output logic               busy_o,
  output logic               result_valid_o,
  output logic [IDX_W-1:0]   winner_o,
  output logic [TALLY_W-1:0] winner_votes_o,
  output logic [TOTAL_W-1:0] total_votes_o,
  output logic               tie_o,
  output logic               no_votes_o
);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [TALLY_W-1:0] snap_q [NUM_CAND];
  logic [TALLY_W-1:0] cand_w [NUM_CAND];

  logic               accept_w;
  logic               step_w;
  logic [TALLY_W-1:0] max_nxt_w;
  logic [IDX_W-1:0]   winner_nxt_w;
  logic               tie_nxt_w;
  logic [TOTAL_W-1:0] total_nxt_w;
  logic               zero_w;

  assign cand_w[0] = cand1_vote_recvd_i;
  assign cand_w[1] = cand2_vote_recvd_i;
  assign cand_w[2] = cand3_vote_recvd_i;
  assign cand_w[3] = cand4_vote_recvd_i;

  assign accept_w = (state_q == ST_IDLE) && start_i && mode_i;
  assign step_w   = (state_q == ST_SCAN);
  assign zero_w   = (total_nxt_w == '0);

  vote_max_tracker u_tracker (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (accept_w),
    .step_i       (step_w),
    .idx_i        (idx_q),
    .entry_i      (snap_q[idx_q]),
    .max_nxt_o    (max_nxt_w),
    .winner_nxt_o (winner_nxt_w),
    .tie_nxt_o    (tie_nxt_w),
    .total_nxt_o  (total_nxt_w)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      for (int i = 0; i < NUM_CAND; i++) snap_q[i] <= '0;
      busy_o         <= 1'b0;
      result_valid_o <= 1'b0;
      winner_o       <= '0;
      winner_votes_o <= '0;
      total_votes_o  <= '0;
      tie_o          <= 1'b0;
      no_votes_o     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_w) begin
            for (int i = 0; i < NUM_CAND; i++) snap_q[i] <= cand_w[i];
            idx_q   <= '0;
            busy_o  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            // Latch the post-step values so the final entry is included.
            state_q        <= ST_DONE;
            busy_o         <= 1'b0;
            result_valid_o <= 1'b1;
            winner_o       <= zero_w ? '0 : winner_nxt_w;
            winner_votes_o <= max_nxt_w;
            total_votes_o  <= total_nxt_w;
            tie_o          <= tie_nxt_w & ~zero_w;
            no_votes_o     <= zero_w;
          end
        end
        ST_DONE: begin
          if (result_ready_i) begin
            result_valid_o <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          busy_o         <= 1'b0;
          result_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vote_result_scanner.md
VOTE_RESULT_SCANNER -- requirements
Module: vote_result_scanner

Interface
REQ-001 clock  input  1  sole clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 mode  input  1  0 = voting, 1 = result; start is accepted only when mode = 1.
REQ-004 start  input  1  request one result scan; level-sampled at each rising edge.
REQ-005 cand1_vote_recvd..cand4_vote_recvd  input  8 each  current tallies from the vote logger.
REQ-006 busy  output  1  high while a scan is in progress.
REQ-007 result_valid  output  1  result fields are valid and stable.
REQ-008 result_ready  input  1  consumer accepts the result.
REQ-009 winner  output  2  index of the winning candidate: 0 = cand1 ... 3 = cand4.
REQ-010 winner_votes  output  8  tally of the winner.
REQ-011 total_votes  output  10  sum of all four tallies.
REQ-012 tie  output  1  another candidate equals winner_votes.
REQ-013 no_votes  output  1  total_votes == 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SCAN, DONE.
REQ-015 IDLE -> SCAN at an edge where start = 1 and mode = 1; that edge SHALL snapshot all four tallies into internal registers, clear the accumulators, and set scan index = 0.
REQ-016 In SCAN, each edge SHALL process the snapshot entry at the current index, then increment the index; the state SHALL go to DONE on the edge that processes index 3.
REQ-017 Latency: result_valid SHALL rise exactly 4 rising edges after the start-acceptance edge.
REQ-018 Tallies changing during SCAN SHALL NOT affect the result; only the snapshot is used.
REQ-019 Processing: total += entry, zero-extended to 10 bits, with no overflow possible (max 1020).
REQ-020 Processing for index 0: the block SHALL load max = entry, winner = 0, tie = 0.
REQ-021 Processing for index > 0, entry > max: the block SHALL set max = entry, winner = index, tie = 0.
REQ-022 Processing for index > 0, entry == max: the block SHALL set tie = 1 and leave winner unchanged, so the lowest index wins.
REQ-023 Processing for index > 0, entry < max: the block SHALL leave max, winner and tie unchanged.
REQ-024 On entry to DONE, no_votes SHALL equal (total == 0); when no_votes = 1, tie SHALL be forced to 0 and winner to 0.
REQ-025 busy SHALL be 1 exactly while in SCAN; result_valid SHALL be 1 exactly while in DONE.
REQ-026 DONE -> IDLE on an edge with result_ready = 1; result_valid SHALL deassert after that edge.
REQ-027 Result fields SHALL hold their last values after the handshake and change only during the next scan.
REQ-028 start SHALL be ignored in SCAN and in DONE, including when start and result_ready are both high in the same cycle.
REQ-029 start SHALL be ignored in IDLE while mode = 0.
REQ-030 A change of mode during SCAN or DONE SHALL NOT abort the scan or the pending result.

Reset
REQ-031 reset = 1 SHALL immediately force state IDLE and clear every output to 0: busy, result_valid, winner, winner_votes, total_votes, tie, no_votes.
REQ-032 reset SHALL also clear the snapshot, the index and the accumulators.
REQ-033 Reset asserted mid-SCAN or in DONE SHALL discard the scan with no result_valid pulse.
REQ-034 After reset release, the block SHALL be ready in IDLE on the first edge.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the constants NUM_CAND = 4, TALLY_W = 8, TOTAL_W = 10.
REQ-036 One sub-module, vote_max_tracker, SHALL hold max, winner, tie and total and apply REQ-019 to REQ-023 per step.
REQ-037 The top level SHALL contain only the FSM, the index counter, the snapshot and the output registers.

Verification
REQ-038 Tallies 5, 9, 3, 7; mode = 1; start pulse -> 4 edges later: result_valid = 1, winner = 1, winner_votes = 9, total = 24, tie = 0.
REQ-039 Tallies 6, 2, 6, 6 -> winner = 0, winner_votes = 6, tie = 1, total = 20; result_ready held 0 for 10 cycles -> outputs stable throughout.
REQ-040 All tallies 0 -> no_votes = 1, tie = 0, winner = 0, total = 0.
REQ-041 Tallies 255 ×4 -> total = 1020, tie = 1; tallies changed mid-SCAN -> result unchanged.
REQ-042 start with mode = 0 -> busy stays 0; start during SCAN or DONE -> no restart, latency per REQ-017.
REQ-043 reset asserted at the second SCAN edge -> all outputs 0 immediately, state IDLE, no result_valid; a new start then completes normally.
